// File: rtl/s2n_row_packer.sv
// Packs a narrow valid/ready element stream into full rows through a 2-bank
// ping-pong, presenting one row at a time on a valid/ready row port.
//
// state | meaning
// IDLE  | waiting for start; input stalled
// RUN   | accepting beats until ROW rows have been assembled
// DRAIN | input stalled; waiting for both banks to be popped
// DONE  | single-cycle frame_done, then back to IDLE
module s2n_row_packer #(
  parameter int WIDTH = 16,
  parameter int COL   = 256,
  parameter int ROW   = 2754,
  parameter int LANES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH*LANES-1:0]     s_data,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [WIDTH*COL-1:0]       m_row,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(ROW+1)-1:0]   row_count,
  output logic                       frame_done,
  output logic                       err_last
);

  localparam int BEATS = COL / LANES;
  localparam int SEG   = WIDTH * LANES;
  localparam int ROW_W = WIDTH * COL;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RCW   = $clog2(ROW + 1);
  localparam int OFFW  = (ROW_W > 1) ? $clog2(ROW_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q;
  logic [ROW_W-1:0]   bank_q [2];
  logic [1:0]         full_q;
  logic               wr_bank_q;
  logic               rd_bank_q;
  logic [BCW-1:0]     beat_cnt_q;
  logic [RCW-1:0]     rows_in_q;
  logic [RCW-1:0]     row_count_q;
  logic               err_last_q;

  logic               push;
  logic               pop;
  logic               last_beat;
  logic               last_row;
  logic [OFFW-1:0]    seg_lo;

  assign s_ready    = (state_q == RUN) && !full_q[wr_bank_q];
  assign m_valid    = full_q[rd_bank_q];
  assign m_row      = bank_q[rd_bank_q];
  assign row_count  = row_count_q;
  assign frame_done = (state_q == DONE);
  assign err_last   = err_last_q;

  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;
  assign last_beat = (beat_cnt_q == BCW'(BEATS - 1));
  assign last_row  = (rows_in_q == RCW'(ROW - 1));
  // Beat 0 lands in the MSBs, so the slice offset counts down with beat_cnt.
  assign seg_lo    = OFFW'((BEATS - 1 - int'(beat_cnt_q)) * SEG);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bank_q[0]   <= '0;
      bank_q[1]   <= '0;
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      beat_cnt_q  <= '0;
      rows_in_q   <= '0;
      row_count_q <= '0;
      err_last_q  <= 1'b0;
    end else begin
      // Push and pop always hit different banks, so both may fire together.
      if (pop) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
        row_count_q       <= row_count_q + RCW'(1);
      end

      if (push) begin
        bank_q[wr_bank_q][seg_lo +: SEG] <= s_data;
        if (s_last != last_beat) err_last_q <= 1'b1;
        if (last_beat) begin
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q         <= ~wr_bank_q;
          beat_cnt_q        <= '0;
          rows_in_q         <= rows_in_q + RCW'(1);
        end else begin
          beat_cnt_q <= beat_cnt_q + BCW'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            row_count_q <= '0;
            rows_in_q   <= '0;
            beat_cnt_q  <= '0;
            err_last_q  <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (push && last_beat && last_row) state_q <= DRAIN;
        end
        DRAIN: begin
          if (full_q == 2'b00) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
